// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking slot allocator.
// Holds the entry FSM state encoding, default sizing constants and a popcount
// helper that is also used by the downstream occupancy counter.
package parking_pkg;

    // Entry FSM state encoding (legacy-compatible constants)
    typedef logic [1:0] alloc_state_t;

    localparam alloc_state_t IDLE   = 2'd0;
    localparam alloc_state_t GRANT  = 2'd1;
    localparam alloc_state_t OPEN   = 2'd2;
    localparam alloc_state_t REJECT = 2'd3;

    localparam int unsigned DEFAULT_NUM_SLOTS        = 8;
    localparam int unsigned DEFAULT_GATE_OPEN_CYCLES = 4;

    // Counts set bits of a vector of up to 16 slots; callers zero-extend
    function automatic logic [4:0] popcount(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/parking_free_finder.sv
// Combinational free-slot search over the occupancy vector.
// Build option PARKING_RR_ALLOC_EN: search starts at 'start' and wraps from
// NUM_SLOTS-1 to 0 (round-robin). Without it the lowest-index free slot wins
// and 'start' is ignored.
module parking_free_finder
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS,
    parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] occupancy,
    input  logic [SLOT_W-1:0]    start,
    output logic                 found,
    output logic [SLOT_W-1:0]    slot
);

`ifdef PARKING_RR_ALLOC_EN
    int unsigned idx;

    // First free slot at or after start, wrapping around the lot
    always_comb begin
        found = 1'b0;
        slot  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            idx = 32'(start) + k;
            if (idx >= NUM_SLOTS) begin
                idx = idx - NUM_SLOTS;
            end
            if (!found && !occupancy[SLOT_W'(idx)]) begin
                found = 1'b1;
                slot  = SLOT_W'(idx);
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    // Lowest-index free slot
    always_comb begin
        found = 1'b0;
        slot  = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !occupancy[SLOT_W'(i)]) begin
                found = 1'b1;
                slot  = SLOT_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking lot entry/exit controller: owns the occupancy vector, grants free
// slots to arriving cars, drives the entry gate and releases exiting slots.
// Build option PARKING_RR_ALLOC_EN selects round-robin slot allocation with a
// start pointer; default build uses lowest-index allocation.
module parking_slot_allocator
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS        = DEFAULT_NUM_SLOTS,
    parameter int unsigned GATE_OPEN_CYCLES = DEFAULT_GATE_OPEN_CYCLES,
    parameter int unsigned SLOT_W           = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    output logic                 entry_ack,
    output logic [SLOT_W-1:0]    entry_slot,
    output logic                 entry_full,
    output logic                 gate_open,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W:0]      free_count
);

    localparam int unsigned CNT_W = $clog2(GATE_OPEN_CYCLES + 1);

    alloc_state_t          state_q, state_d;
    logic [NUM_SLOTS-1:0]  occ_q, occ_d;
    logic [SLOT_W:0]       free_q, free_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  full_q, full_d;
    logic                  gate_q, gate_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;

    logic                  found;
    logic [SLOT_W-1:0]     found_slot;
    logic [SLOT_W-1:0]     start_ptr;
    logic                  exit_valid;
    logic                  exit_hit;

`ifdef PARKING_RR_ALLOC_EN
    logic [SLOT_W-1:0]     ptr_q, ptr_d;
    assign start_ptr = ptr_q;
`else
    assign start_ptr = '0;
`endif

    // Search runs on the registered (pre-exit) occupancy, so a slot freed this
    // cycle neither affects the full decision nor the grant choice.
    parking_free_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_free_finder (
        .occupancy (occ_q),
        .start     (start_ptr),
        .found     (found),
        .slot      (found_slot)
    );

    assign exit_valid = {1'b0, exit_slot} < (SLOT_W + 1)'(NUM_SLOTS);
    assign exit_hit   = exit_valid && occ_q[exit_slot];

    // Exit handling and entry FSM next-state; grant and exit never hit the same slot
    always_comb begin
        occ_d    = occ_q;
        exit_ack = 1'b0;
        exit_err = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        full_d   = 1'b0;
        gate_d   = 1'b0;
        slot_d   = slot_q;
`ifdef PARKING_RR_ALLOC_EN
        ptr_d    = ptr_q;
`endif

        if (exit_req) begin
            if (exit_hit) begin
                exit_ack         = 1'b1;
                occ_d[exit_slot] = 1'b0;
            end else begin
                exit_err = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (entry_req) begin
                    state_d = found ? GRANT : REJECT;
                end
            end
            GRANT: begin
                occ_d[found_slot] = 1'b1;
                ack_d             = 1'b1;
                slot_d            = found_slot;
                cnt_d             = CNT_W'(GATE_OPEN_CYCLES);
                state_d           = OPEN;
`ifdef PARKING_RR_ALLOC_EN
                ptr_d = (32'(found_slot) == NUM_SLOTS - 1) ? '0 : found_slot + 1'b1;
`endif
            end
            OPEN: begin
                if (cnt_q != '0) begin
                    gate_d = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REJECT: begin
                full_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        free_d = (SLOT_W + 1)'(NUM_SLOTS) - (SLOT_W + 1)'(popcount(16'(occ_d)));
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            occ_q   <= '0;
            free_q  <= (SLOT_W + 1)'(NUM_SLOTS);
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            full_q  <= 1'b0;
            gate_q  <= 1'b0;
            slot_q  <= '0;
`ifdef PARKING_RR_ALLOC_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            free_q  <= free_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            full_q  <= full_d;
            gate_q  <= gate_d;
            slot_q  <= slot_d;
`ifdef PARKING_RR_ALLOC_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign entry_ack  = ack_q;
    assign entry_full = full_q;
    assign entry_slot = slot_q;
    assign gate_open  = gate_q;
    assign occupancy  = occ_q;
    assign free_count = free_q;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Self-checking bench for parking_slot_allocator: directed scenarios plus a
// randomized entry/exit mix, checked against a slot-array model of the lot.
module tb_parking_slot_allocator;

    localparam int N  = 8;
    localparam int G  = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          entry_req;
    logic          entry_ack;
    logic [SW-1:0] entry_slot;
    logic          entry_full;
    logic          gate_open;
    logic          exit_req;
    logic [SW-1:0] exit_slot;
    logic          exit_ack;
    logic          exit_err;
    logic [N-1:0]  occupancy;
    logic [SW:0]   free_count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: which slots hold a car, plus round-robin start
    bit m_occ[N];
    int m_ptr;

    parking_slot_allocator #(
        .NUM_SLOTS        (N),
        .GATE_OPEN_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entry_req  (entry_req),
        .entry_ack  (entry_ack),
        .entry_slot (entry_slot),
        .entry_full (entry_full),
        .gate_open  (gate_open),
        .exit_req   (exit_req),
        .exit_slot  (exit_slot),
        .exit_ack   (exit_ack),
        .exit_err   (exit_err),
        .occupancy  (occupancy),
        .free_count (free_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_pick();
        int start = 0;
`ifdef PARKING_RR_ALLOC_EN
        start = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (!m_occ[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int m_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_occ[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int m_free();
        int f = N;
        for (int i = 0; i < N; i++) if (m_occ[i]) f--;
        return f;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic m_grant(input int s);
        m_occ[s] = 1'b1;
        m_ptr    = (s + 1) % N;
    endtask

    task automatic check_lot(input string tag);
        check_eq({tag, "_occ"}, int'(occupancy), m_vec());
        check_eq({tag, "_free"}, int'(free_count), m_free());
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_clear();
        check_lot("reset");
        check_eq("reset_gate", int'(gate_open), 0);
        check_eq("reset_ack", int'(entry_ack), 0);
        check_eq("reset_full", int'(entry_full), 0);
        check_eq("reset_slot", int'(entry_slot), 0);
        rst_n = 1'b1;
    endtask

    // One car at the entry: checks latency, verdict, slot and gate duration
    task automatic do_entry(input string tag);
        int exp   = m_pick();
        int n     = 0;
        int highs = 0;
        bit resp  = 1'b0;
        @(posedge clk); #1;
        entry_req = 1'b1;
        while (!resp && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            resp = entry_ack | entry_full;
        end
        entry_req = 1'b0;
        check_eq({tag, "_resp"}, int'(resp), 1);
        check_eq({tag, "_lat"}, n, 2);
        check_eq({tag, "_ack"}, int'(entry_ack), exp >= 0 ? 1 : 0);
        check_eq({tag, "_full"}, int'(entry_full), exp < 0 ? 1 : 0);
        if (exp >= 0) begin
            check_eq({tag, "_slot"}, int'(entry_slot), exp);
            m_grant(exp);
        end
        check_lot(tag);
        check_eq({tag, "_gate_early"}, int'(gate_open), 0);
        @(negedge clk);
        check_eq({tag, "_pulse"}, int'(entry_ack | entry_full), 0);
        highs += int'(gate_open);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            highs += int'(gate_open);
        end
        check_eq({tag, "_gate_cycles"}, highs, exp >= 0 ? G : 0);
    endtask

    task automatic do_exit(input string tag, input int s);
        bit hit = m_occ[s];
        @(posedge clk); #1;
        exit_req  = 1'b1;
        exit_slot = SW'(s);
        @(negedge clk);
        check_eq({tag, "_xack"}, int'(exit_ack), hit ? 1 : 0);
        check_eq({tag, "_xerr"}, int'(exit_err), hit ? 0 : 1);
        @(posedge clk); #1;
        exit_req = 1'b0;
        if (hit) m_occ[s] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_xidle"}, int'(exit_ack | exit_err), 0);
        check_lot(tag);
    endtask

    // Exit lands in the GRANT cycle: both updates must apply
    task automatic grant_with_exit(input int s);
        int exp = m_pick();
        @(posedge clk); #1;
        entry_req = 1'b1;
        @(posedge clk); #1;
        exit_req  = 1'b1;
        exit_slot = SW'(s);
        @(negedge clk);
        check_eq("gx_xack", int'(exit_ack), 1);
        @(posedge clk); #1;
        exit_req = 1'b0;
        @(negedge clk);
        entry_req = 1'b0;
        check_eq("gx_ack", int'(entry_ack), 1);
        check_eq("gx_slot", int'(entry_slot), exp);
        m_grant(exp);
        m_occ[s] = 1'b0;
        check_lot("gx");
        repeat (8) @(negedge clk);
    endtask

    // Lot full; exit coincides with the IDLE decision, which still rejects
    task automatic full_with_exit(input int s);
        @(posedge clk); #1;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = SW'(s);
        @(negedge clk);
        check_eq("fx_xack", int'(exit_ack), 1);
        @(posedge clk); #1;
        exit_req = 1'b0;
        m_occ[s] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        entry_req = 1'b0;
        check_eq("fx_full", int'(entry_full), 1);
        check_eq("fx_ack", int'(entry_ack), 0);
        check_lot("fx");
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_mid_open();
        @(posedge clk); #1;
        entry_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        entry_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rmo_gate_pre", int'(gate_open), 1);
        @(posedge clk);
        @(negedge clk);
        m_clear();
        check_eq("rmo_gate", int'(gate_open), 0);
        check_lot("rmo");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = '0;
        m_clear();

        do_reset();
        do_entry("first");
        check_eq("first_occ_hex", int'(occupancy), 'h01);
        for (int i = 0; i < 7; i++) do_entry("fill");
        do_entry("full");
        check_eq("full_occ_hex", int'(occupancy), 'hFF);
        do_exit("exit5", 5);
        check_eq("exit5_occ_hex", int'(occupancy), 'hDF);
        do_entry("regrant5");
        do_exit("exit2", 2);
        do_exit("exit2_again", 2);
        do_entry("refill");
        full_with_exit(6);
        do_entry("after_fx");

        do_reset();
        for (int i = 0; i < 7; i++) do_entry("fill7");
        grant_with_exit(3);
        check_eq("gx_occ_hex", int'(occupancy), 'hF7);

        reset_mid_open();
        do_entry("post_rmo");

`ifdef PARKING_RR_ALLOC_EN
        do_reset();
        for (int i = 0; i < 3; i++) do_entry("rr_fill");
        do_exit("rr_exit0", 0);
        do_entry("rr_next");
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) do_entry("rnd_entry");
            else do_exit("rnd_exit", int'($urandom_range(0, N - 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
